// File: rtl/dsp_cascade_tx.sv
// Driving end of the DSP slice cascade: the B-cascade pipeline, the P/PCOUT register
// and the carry-out register, each with its own clock enable and sync clear.
module dsp_cascade_tx #(
    parameter int B_WIDTH = 18,
    parameter int P_WIDTH = 48,
    parameter int BREG    = 1,
    parameter int PREG    = 1,
    parameter int CYOREG  = 1
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               CEB,
    input  logic               CEP,
    input  logic               CECARRY,
    input  logic               RSTB,
    input  logic               RSTP,
    input  logic               RSTCARRY,
    input  logic [B_WIDTH-1:0] B_IN,
    input  logic [P_WIDTH-1:0] P_IN,
    input  logic               CARRY_IN,
    input  logic               VALID_IN,
    output logic [B_WIDTH-1:0] BCOUT,
    output logic [P_WIDTH-1:0] P,
    output logic [P_WIDTH-1:0] PCOUT,
    output logic               CARRYOUT,
    output logic               CARRYOUTF,
    output logic               VALID_OUT
);

    // VALID_IN qualifies P_IN/CARRY_IN in the same cycle; VALID_OUT qualifies P/PCOUT/CARRYOUT.
    // There is no ready: the next slice always accepts, and with CEP low the held VALID_OUT
    // re-presents the same datum rather than a new one.

    if (BREG < 0 || BREG > 2) begin : g_breg_bad
        $error("dsp_cascade_tx: BREG must be 0, 1 or 2");
    end
    if (PREG < 0 || PREG > 1) begin : g_preg_bad
        $error("dsp_cascade_tx: PREG must be 0 or 1");
    end
    if (CYOREG < 0 || CYOREG > 1) begin : g_cyoreg_bad
        $error("dsp_cascade_tx: CYOREG must be 0 or 1");
    end

    // B cascade: stage 0 captures B_IN, later stages shift only when CEB is high.
    if (BREG == 0) begin : g_b_comb
        assign BCOUT = B_IN;
    end else begin : g_b_reg
        logic [B_WIDTH-1:0] b_stage [BREG];

        always_ff @(posedge CLK or negedge RST_N) begin
            if (!RST_N) begin
                for (int i = 0; i < BREG; i++) b_stage[i] <= '0;
            end else if (RSTB) begin
                for (int i = 0; i < BREG; i++) b_stage[i] <= '0;
            end else if (CEB) begin
                b_stage[0] <= B_IN;
                for (int i = 1; i < BREG; i++) b_stage[i] <= b_stage[i-1];
            end
        end

        assign BCOUT = b_stage[BREG-1];
    end

    // P and VALID share CEP/RSTP so VALID_OUT always tags the word on P.
    if (PREG == 0) begin : g_p_comb
        assign P         = P_IN;
        assign VALID_OUT = VALID_IN;
    end else begin : g_p_reg
        logic [P_WIDTH-1:0] p_q;
        logic               valid_q;

        always_ff @(posedge CLK or negedge RST_N) begin
            if (!RST_N) begin
                p_q     <= '0;
                valid_q <= 1'b0;
            end else if (RSTP) begin
                p_q     <= '0;
                valid_q <= 1'b0;
            end else if (CEP) begin
                p_q     <= P_IN;
                valid_q <= VALID_IN;
            end
        end

        assign P         = p_q;
        assign VALID_OUT = valid_q;
    end

    if (CYOREG == 0) begin : g_c_comb
        assign CARRYOUT = CARRY_IN;
    end else begin : g_c_reg
        logic carry_q;

        always_ff @(posedge CLK or negedge RST_N) begin
            if (!RST_N) begin
                carry_q <= 1'b0;
            end else if (RSTCARRY) begin
                carry_q <= 1'b0;
            end else if (CECARRY) begin
                carry_q <= CARRY_IN;
            end
        end

        assign CARRYOUT = carry_q;
    end

    assign PCOUT     = P;
    assign CARRYOUTF = CARRYOUT;

endmodule

// File: tb/tb_dsp_cascade_tx.sv
// Bench for dsp_cascade_tx: default, two-deep B, and full pass-through instances
// driven from one shared stimulus and checked against a queue-based model.
module tb_dsp_cascade_tx;

    localparam int BW = 18;
    localparam int PW = 48;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ceb, cep, cec, rstb, rstp, rstc;
    logic [BW-1:0] b_in;
    logic [PW-1:0] p_in;
    logic          carry_in, valid_in;

    logic [BW-1:0] bcout_def, bcout_b2, bcout_pt;
    logic [PW-1:0] p_def, p_b2, p_pt, pcout_def, pcout_b2, pcout_pt;
    logic          co_def, co_b2, co_pt, cof_def, cof_b2, cof_pt;
    logic          vo_def, vo_b2, vo_pt;

    int n_cmp = 0;
    int n_bad = 0;

    // clock / reset
    always #5 clk = ~clk;

    dsp_cascade_tx #(.B_WIDTH(BW), .P_WIDTH(PW), .BREG(1), .PREG(1), .CYOREG(1)) u_def (
        .CLK(clk), .RST_N(rst_n), .CEB(ceb), .CEP(cep), .CECARRY(cec),
        .RSTB(rstb), .RSTP(rstp), .RSTCARRY(rstc),
        .B_IN(b_in), .P_IN(p_in), .CARRY_IN(carry_in), .VALID_IN(valid_in),
        .BCOUT(bcout_def), .P(p_def), .PCOUT(pcout_def),
        .CARRYOUT(co_def), .CARRYOUTF(cof_def), .VALID_OUT(vo_def));

    dsp_cascade_tx #(.B_WIDTH(BW), .P_WIDTH(PW), .BREG(2), .PREG(1), .CYOREG(0)) u_b2 (
        .CLK(clk), .RST_N(rst_n), .CEB(ceb), .CEP(cep), .CECARRY(cec),
        .RSTB(rstb), .RSTP(rstp), .RSTCARRY(rstc),
        .B_IN(b_in), .P_IN(p_in), .CARRY_IN(carry_in), .VALID_IN(valid_in),
        .BCOUT(bcout_b2), .P(p_b2), .PCOUT(pcout_b2),
        .CARRYOUT(co_b2), .CARRYOUTF(cof_b2), .VALID_OUT(vo_b2));

    dsp_cascade_tx #(.B_WIDTH(BW), .P_WIDTH(PW), .BREG(0), .PREG(0), .CYOREG(0)) u_pt (
        .CLK(clk), .RST_N(rst_n), .CEB(ceb), .CEP(cep), .CECARRY(cec),
        .RSTB(rstb), .RSTP(rstp), .RSTCARRY(rstc),
        .B_IN(b_in), .P_IN(p_in), .CARRY_IN(carry_in), .VALID_IN(valid_in),
        .BCOUT(bcout_pt), .P(p_pt), .PCOUT(pcout_pt),
        .CARRYOUT(co_pt), .CARRYOUTF(cof_pt), .VALID_OUT(vo_pt));

    // Reference model: each B cascade is the list of the last N accepted samples.
    logic [BW-1:0] bq_def[$];
    logic [BW-1:0] bq_b2[$];
    logic [PW-1:0] p_m;
    logic          v_m, c_m;

    task automatic model_reset();
        bq_def = '{18'h0};
        bq_b2  = '{18'h0, 18'h0};
        p_m = '0;
        v_m = 1'b0;
        c_m = 1'b0;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_reset();
        end else begin
            if (rstb) begin
                bq_def = '{18'h0};
                bq_b2  = '{18'h0, 18'h0};
            end else if (ceb) begin
                bq_def.push_front(b_in);
                void'(bq_def.pop_back());
                bq_b2.push_front(b_in);
                void'(bq_b2.pop_back());
            end
            if (rstp) begin
                p_m = '0;
                v_m = 1'b0;
            end else if (cep) begin
                p_m = p_in;
                v_m = valid_in;
            end
            if (rstc)     c_m = 1'b0;
            else if (cec) c_m = carry_in;
        end
    end

    // scoreboard
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, " def.bcout"}, 64'(bcout_def), 64'(bq_def[$]));
        chk({tag, " def.p"},     64'(p_def),     64'(p_m));
        chk({tag, " def.pcout"}, 64'(pcout_def), 64'(p_m));
        chk({tag, " def.co"},    64'(co_def),    64'(c_m));
        chk({tag, " def.cof"},   64'(cof_def),   64'(c_m));
        chk({tag, " def.vo"},    64'(vo_def),    64'(v_m));
        chk({tag, " b2.bcout"},  64'(bcout_b2),  64'(bq_b2[$]));
        chk({tag, " b2.p"},      64'(p_b2),      64'(p_m));
        chk({tag, " b2.pcout"},  64'(pcout_b2),  64'(p_m));
        chk({tag, " b2.co"},     64'(co_b2),     64'(carry_in));
        chk({tag, " b2.cof"},    64'(cof_b2),    64'(carry_in));
        chk({tag, " b2.vo"},     64'(vo_b2),     64'(v_m));
        chk({tag, " pt.bcout"},  64'(bcout_pt),  64'(b_in));
        chk({tag, " pt.p"},      64'(p_pt),      64'(p_in));
        chk({tag, " pt.pcout"},  64'(pcout_pt),  64'(p_in));
        chk({tag, " pt.co"},     64'(co_pt),     64'(carry_in));
        chk({tag, " pt.cof"},    64'(cof_pt),    64'(carry_in));
        chk({tag, " pt.vo"},     64'(vo_pt),     64'(valid_in));
    endtask

    // driver tasks
    task automatic drive(input logic ceb_i, input logic cep_i, input logic cec_i,
                         input logic rstb_i, input logic rstp_i, input logic rstc_i,
                         input logic [BW-1:0] b_i, input logic [PW-1:0] p_i,
                         input logic cy_i, input logic v_i);
        ceb = ceb_i; cep = cep_i; cec = cec_i;
        rstb = rstb_i; rstp = rstp_i; rstc = rstc_i;
        b_in = b_i; p_in = p_i; carry_in = cy_i; valid_in = v_i;
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    typedef struct {
        logic          ceb, cep, cec, rstb, rstp, rstc;
        logic [BW-1:0] b;
        logic [PW-1:0] p;
        logic          cy, v;
        logic [BW-1:0] e_b;
        logic [PW-1:0] e_p;
        logic          e_c, e_v;
    } vec_t;

    vec_t vecs[6];

    initial begin
        // expected values are those of the default instance after the edge
        vecs[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 18'h3FFFF, 48'hFFFF_FFFF_FFFF, 1'b1, 1'b1,
                    18'h3FFFF, 48'hFFFF_FFFF_FFFF, 1'b1, 1'b1};
        vecs[1] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 18'h00001, 48'h2, 1'b0, 1'b0,
                    18'h3FFFF, 48'hFFFF_FFFF_FFFF, 1'b1, 1'b1};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 18'h00005, 48'h0123_4567_89AB, 1'b0, 1'b1,
                    18'h0, 48'h0, 1'b1, 1'b0};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 18'h2AAAA, 48'h0000_5555_AAAA, 1'b1, 1'b1,
                    18'h2AAAA, 48'h0000_5555_AAAA, 1'b0, 1'b1};
        vecs[4] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 18'h15555, 48'h8000_0000_0001, 1'b1, 1'b0,
                    18'h0, 48'h8000_0000_0001, 1'b1, 1'b0};
        vecs[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 18'h00001, 48'h0, 1'b0, 1'b1,
                    18'h00001, 48'h0, 1'b0, 1'b1};

        model_reset();

        // reset state with every input driven high
        drive(1, 1, 1, 0, 0, 0, 18'h3FFFF, 48'hFFFF_FFFF_FFFF, 1, 1);
        #3;
        chk("rst bcout", 64'(bcout_def), 64'h0);
        chk("rst p",     64'(p_def),     64'h0);
        chk("rst co",    64'(co_def),    64'h0);
        chk("rst vo",    64'(vo_def),    64'h0);
        check_all("rst");
        @(negedge clk);
        rst_n = 1'b1;

        // table-driven vectors
        for (int i = 0; i < 6; i++) begin
            drive(vecs[i].ceb, vecs[i].cep, vecs[i].cec, vecs[i].rstb, vecs[i].rstp, vecs[i].rstc,
                  vecs[i].b, vecs[i].p, vecs[i].cy, vecs[i].v);
            step($sformatf("vec%0d", i));
            chk($sformatf("vec%0d bcout", i), 64'(bcout_def), 64'(vecs[i].e_b));
            chk($sformatf("vec%0d p", i),     64'(p_def),     64'(vecs[i].e_p));
            chk($sformatf("vec%0d co", i),    64'(co_def),    64'(vecs[i].e_c));
            chk($sformatf("vec%0d vo", i),    64'(vo_def),    64'(vecs[i].e_v));
            @(negedge clk);
        end

        // two-deep B cascade: latency, stall and resume
        drive(0, 1, 1, 1, 0, 0, 18'h0, 48'h0, 0, 0);
        step("b2clr");
        @(negedge clk); drive(1, 1, 1, 0, 0, 0, 18'd5, 48'h10, 1, 1); step("b2e1");
        chk("b2 seq e1", 64'(bcout_b2), 64'd0);
        @(negedge clk); b_in = 18'd6; step("b2e2");
        chk("b2 seq e2", 64'(bcout_b2), 64'd5);
        @(negedge clk); b_in = 18'd7; step("b2e3");
        chk("b2 seq e3", 64'(bcout_b2), 64'd6);
        @(negedge clk); b_in = 18'd9; ceb = 1'b0; step("b2e4");
        chk("b2 stall", 64'(bcout_b2), 64'd6);
        @(negedge clk); ceb = 1'b1; step("b2e5");
        chk("b2 resume1", 64'(bcout_b2), 64'd7);
        @(negedge clk); b_in = 18'd0; step("b2e6");
        chk("b2 resume2", 64'(bcout_b2), 64'd9);

        // randomized stimulus against the model
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            drive($urandom_range(3, 0) != 0, $urandom_range(3, 0) != 0, $urandom_range(3, 0) != 0,
                  $urandom_range(7, 0) == 0, $urandom_range(7, 0) == 0, $urandom_range(7, 0) == 0,
                  BW'($urandom), {$urandom(), $urandom()} & {PW{1'b1}} ,
                  1'($urandom), 1'($urandom));
            step("rnd");
        end

        // mid-stream async reset with the two-deep cascade full
        @(negedge clk); drive(1, 1, 1, 0, 0, 0, 18'h21, 48'hABC, 1, 1); step("ms1");
        @(negedge clk); b_in = 18'h22; step("ms2");
        #2;
        rst_n = 1'b0;
        #1;
        chk("ms b2 bcout", 64'(bcout_b2), 64'h0);
        chk("ms def p",    64'(p_def),    64'h0);
        chk("ms def vo",   64'(vo_def),   64'h0);
        check_all("ms_rst");
        b_in = 18'h33; p_in = 48'h7777; carry_in = 1'b0; valid_in = 1'b0;
        #1;
        check_all("ms_rst_pt");
        @(negedge clk);
        rst_n = 1'b1;
        b_in = 18'h44;
        step("ms_r1");
        chk("ms after e1", 64'(bcout_b2), 64'h0);
        @(negedge clk); b_in = 18'h55; step("ms_r2");
        chk("ms after e2", 64'(bcout_b2), 64'h44);

        // final report
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
